ctrl_pipe_regs: RTL and testbench
=================================

# ctrl_pipe_regs

- Receives the decoded control bundle from the ID-stage control decoder, one instruction per cycle.
- Carries that bundle down the pipeline through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards: requests a one-cycle stall and inserts a bubble.
- On a taken branch or jump, squashes the wrong-path instructions.

## Interface

Parameters:
- CNT_W, 16, width of the saturating performance counters (used only when CTRL_PERF_CNT_EN is defined)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction; when 0, all control inputs are ignored and treated as a bubble
- RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump  in  1 each  decoded controls from the ID stage
- ALUOp  in  2  decoded ALU operation class
- id_rs, id_rt, id_rd  in  5 each  register fields of the ID-stage instruction
- flush  in  1  branch/jump resolved taken (asserted by the MEM stage)
- stall  out  1  hold PC and the IF/ID register this cycle
- ex_ALUSrc, ex_Branch, ex_Jump  out  1 each  EX-stage controls
- ex_ALUOp  out  2  EX-stage ALU class
- ex_wreg  out  5  EX-stage destination register
- mem_MemRead, mem_MemWrite, mem_Branch, mem_Jump  out  1 each  MEM-stage controls
- wb_RegWrite, wb_MemtoReg  out  1 each  WB-stage controls
- wb_wreg  out  5  WB-stage destination register
- stall_cnt, flush_cnt  out  CNT_W each  performance counters (present only when CTRL_PERF_CNT_EN is defined)

## Operation

EX-register capture (each edge, when neither flush nor stall applies):
- Captured: all ID controls, masked by id_valid.
- Destination: ex_wreg = id_rd if RegDst==1, else id_rt. Any non-1 value of RegDst, including X, selects id_rt.
- RegWrite, MemtoReg, MemRead and MemWrite are also held internally in the EX stage for forwarding down the pipe.

Stage advance:
- EX to MEM: unconditional each cycle.
- MEM to WB: unconditional each cycle.
- The destination register travels with the instruction (ex_wreg, then mem_wreg, then wb_wreg).

Load-use hazard (combinational):
- stall = id_valid & ex_MemRead & (ex_wreg != 0) & (ex_wreg == id_rs | ex_wreg == id_rt).
- When stall=1, the EX register loads an all-zero bubble, and the ID instruction is re-presented next cycle by the held IF/ID register.

Flush:
- flush=1 at an edge loads zero bubbles into both the EX and the MEM registers.
- The MEM-to-WB transfer proceeds normally, so the branch itself retires.
- While flush=1, the stall output is forced to 0.

Priority:
- rst > flush > stall > normal capture.

Bubbles:
- A bubble has every control at 0 and its destination register at 0.
- A bubble therefore never writes memory or the register file.

## Timing

- Reset: every registered output is 0, counters are 0, and stall reads 0.
- Latency: ID inputs appear on ex_* one edge later, on mem_* two edges later and on wb_* three edges later.
- stall is combinational from the current EX register and the ID inputs; it has no registered delay.
- A single load-use stall lasts exactly 1 cycle: at the next edge the load moves to MEM and ex_MemRead becomes 0.
- flush and a coincident stall in the same cycle: the flush wins, no stall is issued, and the EX register gets a bubble.
- rst asserted mid-operation clears all stages at that edge; instructions in flight are lost.
- A register-0 destination never triggers a stall.

## Configuration

CTRL_PERF_CNT_EN:
- Defined: stall_cnt increments on every edge where stall=1 and rst=0. flush_cnt increments on every edge where flush=1 and rst=0. Both saturate at 2^CNT_W-1 and are cleared by rst.
- Undefined: the counters and their ports are absent; functional behaviour is identical.

## Test plan

- Reset: rst=1 for 2 cycles, then an R-format (RegDst=1, RegWrite=1, ALUOp=10, rd=5) with id_valid=1. Required: all outputs 0 during reset; ex_wreg=5 and ex_ALUOp=10 after 1 edge; wb_RegWrite=1 and wb_wreg=5 after 3 edges.
- Load-use: LW with rt=8 (MemRead=1, RegDst=0), followed by an R-format with rs=8. Required: stall=1 for exactly one cycle; the EX stage holds a bubble (all 0) on the following edge; the R-format reaches EX one cycle later.
- No false stall: LW with rt=0, followed by an instruction with rs=0. Required: stall stays 0. The same holds for LW rt=8 followed by an instruction using rs=9, rt=10.
- Flush: BEQ in MEM with flush=1 while LW and ADDIU occupy EX and ID. Required: mem_* and ex_* are all 0 after the edge, and the BEQ appears at WB.
- Flush with stall: load-use condition present and flush=1 in the same cycle. Required: stall=0, the EX register gets a bubble, and (with CTRL_PERF_CNT_EN defined) flush_cnt increments while stall_cnt does not.
- Saturation (CTRL_PERF_CNT_EN defined, CNT_W=4): 20 stall events. Required: stall_cnt=15.

Source files
------------

// File: rtl/ctrl_pipe_regs.sv
// ID/EX, EX/MEM and MEM/WB control registers with load-use stall and flush squash.
// Optional saturating stall/flush counters are enabled by defining CTRL_PERF_CNT_EN.
module ctrl_pipe_regs #(
  parameter int unsigned CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic       RegDst,
  input  logic       ALUSrc,
  input  logic       MemtoReg,
  input  logic       RegWrite,
  input  logic       MemRead,
  input  logic       MemWrite,
  input  logic       Branch,
  input  logic       Jump,
  input  logic [1:0] ALUOp,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       flush,
  output logic       stall,
  output logic       ex_ALUSrc,
  output logic       ex_Branch,
  output logic       ex_Jump,
  output logic [1:0] ex_ALUOp,
  output logic [4:0] ex_wreg,
  output logic       mem_MemRead,
  output logic       mem_MemWrite,
  output logic       mem_Branch,
  output logic       mem_Jump,
  output logic       wb_RegWrite,
  output logic       wb_MemtoReg,
  output logic [4:0] wb_wreg
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef struct packed {
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic [1:0] aluop;
    logic       regwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic [4:0] wreg;
  } ex_ctrl_t;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic [4:0] wreg;
  } mem_ctrl_t;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic [4:0] wreg;
  } wb_ctrl_t;

  ex_ctrl_t  id_ctrl;
  ex_ctrl_t  ex_d, ex_q;
  mem_ctrl_t mem_d, mem_q;
  wb_ctrl_t  wb_d, wb_q;
  logic      hazard;

  // Only an exact 1 on RegDst picks rd; anything else (including X) falls to rt.
  always_comb begin
    id_ctrl = '0;
    if (id_valid) begin
      id_ctrl.alusrc   = ALUSrc;
      id_ctrl.branch   = Branch;
      id_ctrl.jump     = Jump;
      id_ctrl.aluop    = ALUOp;
      id_ctrl.regwrite = RegWrite;
      id_ctrl.memtoreg = MemtoReg;
      id_ctrl.memread  = MemRead;
      id_ctrl.memwrite = MemWrite;
      if (RegDst == 1'b1) id_ctrl.wreg = id_rd;
      else                id_ctrl.wreg = id_rt;
    end
  end

  always_comb begin
    hazard = id_valid & ex_q.memread & (ex_q.wreg != 5'd0) &
             ((ex_q.wreg == id_rs) | (ex_q.wreg == id_rt));
    stall  = hazard & ~flush;
  end

  always_comb begin
    ex_d  = id_ctrl;
    mem_d = '{regwrite: ex_q.regwrite, memtoreg: ex_q.memtoreg,
              memread:  ex_q.memread,  memwrite: ex_q.memwrite,
              branch:   ex_q.branch,   jump:     ex_q.jump,
              wreg:     ex_q.wreg};
    wb_d  = '{regwrite: mem_q.regwrite, memtoreg: mem_q.memtoreg, wreg: mem_q.wreg};
    if (flush) begin
      ex_d  = '0;
      mem_d = '0;
    end else if (stall) begin
      ex_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ex_ALUSrc    = ex_q.alusrc;
  assign ex_Branch    = ex_q.branch;
  assign ex_Jump      = ex_q.jump;
  assign ex_ALUOp     = ex_q.aluop;
  assign ex_wreg      = ex_q.wreg;
  assign mem_MemRead  = mem_q.memread;
  assign mem_MemWrite = mem_q.memwrite;
  assign mem_Branch   = mem_q.branch;
  assign mem_Jump     = mem_q.jump;
  assign wb_RegWrite  = wb_q.regwrite;
  assign wb_MemtoReg  = wb_q.memtoreg;
  assign wb_wreg      = wb_q.wreg;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Scoreboard bench for ctrl_pipe_regs: directed test-plan sequences then random traffic,
// checked against a stage-by-stage instruction model.
module tb_ctrl_pipe_regs;

`ifdef CTRL_PERF_CNT_EN
  localparam int unsigned CNT_W = 4;
`else
  localparam int unsigned CNT_W = 16;
`endif
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       valid, regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, jump;
    logic [1:0] aluop;
    logic [4:0] rs, rt, rd;
  } id_t;

  // What an instruction carries once decoded: its controls and destination.
  typedef struct packed {
    logic       alusrc, branch, jump;
    logic [1:0] aluop;
    logic       regwrite, memtoreg, memread, memwrite;
    logic [4:0] wreg;
  } instr_t;

  typedef struct packed {
    logic [9:0]  ex;
    logic [3:0]  mem;
    logic [6:0]  wb;
    logic [15:0] scnt, fcnt;
  } snap_t;

  logic clk = 1'b0;
  logic rst, id_valid, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, flush;
  logic [1:0] ALUOp;
  logic [4:0] id_rs, id_rt, id_rd;
  logic stall, ex_ALUSrc, ex_Branch, ex_Jump;
  logic [1:0] ex_ALUOp;
  logic [4:0] ex_wreg, wb_wreg;
  logic mem_MemRead, mem_MemWrite, mem_Branch, mem_Jump, wb_RegWrite, wb_MemtoReg;
`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  ctrl_pipe_regs #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .RegDst(RegDst), .ALUSrc(ALUSrc),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .Jump(Jump), .ALUOp(ALUOp), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush), .stall(stall), .ex_ALUSrc(ex_ALUSrc), .ex_Branch(ex_Branch),
    .ex_Jump(ex_Jump), .ex_ALUOp(ex_ALUOp), .ex_wreg(ex_wreg), .mem_MemRead(mem_MemRead),
    .mem_MemWrite(mem_MemWrite), .mem_Branch(mem_Branch), .mem_Jump(mem_Jump),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_wreg(wb_wreg)
`ifdef CTRL_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic  stall_q[$];
  snap_t snap_q[$];

  // Reference pipeline: one instruction per stage.
  instr_t m_ex = '0, m_mem = '0, m_wb = '0;
  int unsigned m_scnt = 0, m_fcnt = 0;
  logic last_stall = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
    end
  endtask

  function automatic instr_t decode(input id_t x);
    instr_t r = '0;
    if (x.valid) begin
      r.alusrc = x.alusrc; r.branch = x.branch; r.jump = x.jump; r.aluop = x.aluop;
      r.regwrite = x.regwrite; r.memtoreg = x.memtoreg;
      r.memread = x.memread; r.memwrite = x.memwrite;
      r.wreg = x.regdst ? x.rd : x.rt;
    end
    return r;
  endfunction

  function automatic snap_t snapshot();
    snap_t s;
    s.ex   = {m_ex.alusrc, m_ex.branch, m_ex.jump, m_ex.aluop, m_ex.wreg};
    s.mem  = {m_mem.memread, m_mem.memwrite, m_mem.branch, m_mem.jump};
    s.wb   = {m_wb.regwrite, m_wb.memtoreg, m_wb.wreg};
    s.scnt = 16'(m_scnt);
    s.fcnt = 16'(m_fcnt);
    return s;
  endfunction

  // One clock: drive ID inputs, predict stall now and the pipeline after the edge.
  task automatic step(input id_t x, input logic f, input logic r);
    logic s;
    @(negedge clk);
    rst = r; flush = f; id_valid = x.valid; RegDst = x.regdst; ALUSrc = x.alusrc;
    MemtoReg = x.memtoreg; RegWrite = x.regwrite; MemRead = x.memread; MemWrite = x.memwrite;
    Branch = x.branch; Jump = x.jump; ALUOp = x.aluop; id_rs = x.rs; id_rt = x.rt; id_rd = x.rd;
    s = !f && x.valid && m_ex.memread && (m_ex.wreg != 0) &&
        ((m_ex.wreg == x.rs) || (m_ex.wreg == x.rt));
    stall_q.push_back(s);
    last_stall = s;
    if (r) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (s && m_scnt < CNT_MAX) m_scnt++;
      if (f && m_fcnt < CNT_MAX) m_fcnt++;
      m_wb  = m_mem;
      m_mem = f ? '0 : m_ex;
      m_ex  = (f || s) ? '0 : decode(x);
    end
    snap_q.push_back(snapshot());
  endtask

  function automatic id_t nop();
    return '0;
  endfunction
  function automatic id_t rtype(input logic [4:0] rs, rt, rd);
    id_t x = '0;
    x.valid = 1; x.regdst = 1; x.regwrite = 1; x.aluop = 2'b10; x.rs = rs; x.rt = rt; x.rd = rd;
    return x;
  endfunction
  function automatic id_t lw(input logic [4:0] rs, rt);
    id_t x = '0;
    x.valid = 1; x.alusrc = 1; x.memtoreg = 1; x.regwrite = 1; x.memread = 1;
    x.rs = rs; x.rt = rt; x.rd = 5'd17;
    return x;
  endfunction
  function automatic id_t addiu(input logic [4:0] rs, rt);
    id_t x = '0;
    x.valid = 1; x.alusrc = 1; x.regwrite = 1; x.rs = rs; x.rt = rt; x.rd = 5'd3;
    return x;
  endfunction
  function automatic id_t beq(input logic [4:0] rs, rt);
    id_t x = '0;
    x.valid = 1; x.branch = 1; x.aluop = 2'b01; x.rs = rs; x.rt = rt; x.rd = 5'd12;
    return x;
  endfunction
  function automatic id_t rand_id();
    id_t x;
    logic [4:0] pool [4];
    x = id_t'($urandom);
    pool[0] = 5'd0; pool[1] = 5'd8; pool[2] = 5'd9; pool[3] = 5'($urandom);
    x.valid = ($urandom_range(0, 9) != 0);
    x.memread = ($urandom_range(0, 2) == 0);
    x.rs = pool[$urandom_range(0, 3)];
    x.rt = pool[$urandom_range(0, 3)];
    return x;
  endfunction

  // Monitor: stall is combinational, sampled mid-low-phase after inputs settle.
  initial forever begin
    @(negedge clk); #2;
    if (stall_q.size() != 0) check("stall", 32'(stall), 32'(stall_q.pop_front()));
  end

  // Monitor: registered outputs, sampled 1 unit after each rising edge.
  initial forever begin
    snap_t e;
    @(posedge clk); #1;
    if (snap_q.size() != 0) begin
      e = snap_q.pop_front();
      check("ex",  32'({ex_ALUSrc, ex_Branch, ex_Jump, ex_ALUOp, ex_wreg}), 32'(e.ex));
      check("mem", 32'({mem_MemRead, mem_MemWrite, mem_Branch, mem_Jump}), 32'(e.mem));
      check("wb",  32'({wb_RegWrite, wb_MemtoReg, wb_wreg}), 32'(e.wb));
`ifdef CTRL_PERF_CNT_EN
      check("stall_cnt", 32'(stall_cnt), 32'(e.scnt));
      check("flush_cnt", 32'(flush_cnt), 32'(e.fcnt));
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    id_t x;
    rst = 1; flush = 0; id_valid = 0; RegDst = 0; ALUSrc = 0; MemtoReg = 0; RegWrite = 0;
    MemRead = 0; MemWrite = 0; Branch = 0; Jump = 0; ALUOp = 0; id_rs = 0; id_rt = 0; id_rd = 0;

    // reset, then R-format rd=5 flowing to WB
    step(nop(), 0, 1); step(nop(), 0, 1);
    step(rtype(5'd1, 5'd2, 5'd5), 0, 0);
    repeat (3) step(nop(), 0, 0);

    // load-use: one stall, instruction re-presented
    step(lw(5'd1, 5'd8), 0, 0);
    step(rtype(5'd8, 5'd3, 5'd4), 0, 0);
    step(rtype(5'd8, 5'd3, 5'd4), 0, 0);
    repeat (3) step(nop(), 0, 0);

    // no false stall: r0 destination, and unrelated sources
    step(lw(5'd1, 5'd0), 0, 0); step(rtype(5'd0, 5'd0, 5'd4), 0, 0);
    step(lw(5'd1, 5'd8), 0, 0); step(rtype(5'd9, 5'd10, 5'd4), 0, 0);
    repeat (3) step(nop(), 0, 0);

    // flush with BEQ in MEM, LW in EX, ADDIU in ID
    step(beq(5'd1, 5'd2), 0, 0);
    step(lw(5'd3, 5'd8), 0, 0);
    step(addiu(5'd4, 5'd6), 1, 0);
    repeat (3) step(nop(), 0, 0);

    // flush coincident with a load-use hazard
    step(lw(5'd1, 5'd8), 0, 0);
    step(rtype(5'd8, 5'd1, 5'd2), 1, 0);
    repeat (3) step(nop(), 0, 0);

    // 20 stall events for counter saturation
    for (int i = 0; i < 20; i++) begin
      step(lw(5'd1, 5'd8), 0, 0);
      step(rtype(5'd8, 5'd1, 5'd2), 0, 0);
      step(rtype(5'd8, 5'd1, 5'd2), 0, 0);
    end

    // random traffic; a stalled instruction is held in ID like a frozen IF/ID
    x = rand_id();
    for (int i = 0; i < 2000; i++) begin
      logic f, r;
      if (!last_stall) x = rand_id();
      f = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 99) == 0);
      step(x, f, r);
    end
    step(nop(), 0, 0);

    for (int i = 0; i < 5 && (snap_q.size() != 0 || stall_q.size() != 0); i++) @(negedge clk);
    #4;
    if (snap_q.size() != 0 || stall_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", snap_q.size() + stall_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
